// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, funct7 constants, format codes
// and the opcode-to-format mapping used by the decoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_INVALID
  } format_e;

  // Every listed opcode ends in 2'b11, so compressed encodings fall to INVALID.
  function automatic format_e format_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:                                   return FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                 return FMT_I;
      OPC_STORE:                                return FMT_S;
      OPC_BRANCH:                               return FMT_B;
      OPC_LUI, OPC_AUIPC:                       return FMT_U;
      OPC_JAL:                                  return FMT_J;
      default:                                  return FMT_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Format-specific RV32I immediate assembly with sign extension.
// R-type and invalid encodings carry no immediate and produce zero.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instruction,
  input  format_e     format,
  output logic [31:0] o_imm_ext
);

  always_comb begin
    o_imm_ext = '0;
    case (format)
      FMT_I: o_imm_ext = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: o_imm_ext = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: o_imm_ext = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: o_imm_ext = {instruction[31:12], 12'b0};
      FMT_J: o_imm_ext = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      default: o_imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_decoder.sv
// RV32I instruction decoder with a saturating illegal-instruction counter.
// Define DECODER_REG_OUT_EN to register all decode outputs (1-cycle latency).
module rv32i_instr_decoder
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [31:0]      i_instruction,
  input  logic             i_clr_cnt,
  output logic             o_valid,
  output logic [6:0]       o_opcode,
  output logic [4:0]       o_rd,
  output logic [2:0]       o_funct3,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [6:0]       o_funct7,
  output logic [11:0]      o_immediate,
  output logic [31:0]      o_imm_ext,
  output logic [2:0]       o_format,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  // o_valid qualifies every decode output; there is no ready, the decoder never stalls.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  format_e     d_format;
  logic [31:0] d_imm_ext;
  logic        d_illegal;

  assign opcode   = i_instruction[6:0];
  assign funct3   = i_instruction[14:12];
  assign funct7   = i_instruction[31:25];
  assign d_format = format_of(opcode);

  rv32i_imm_gen u_imm_gen (
    .instruction (i_instruction[31:7]),
    .format      (d_format),
    .o_imm_ext   (d_imm_ext)
  );

  always_comb begin
    d_illegal = (d_format == FMT_INVALID);
    case (opcode)
      OPC_BRANCH: if (funct3 == 3'b010 || funct3 == 3'b011) d_illegal = 1'b1;
      OPC_LOAD:   if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_illegal = 1'b1;
      OPC_STORE:  if (funct3 > 3'b010) d_illegal = 1'b1;
      OPC_JALR:   if (funct3 != 3'b000) d_illegal = 1'b1;
      OPC_OP: begin
        if (funct7 != F7_BASE && funct7 != F7_ALT) d_illegal = 1'b1;
        else if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101) d_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-immediates reuse the funct7 field.
        if (funct3 == 3'b001 && funct7 != F7_BASE) d_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) d_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Counts from the combinational flag in both output modes; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_illegal_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_illegal_cnt <= '0;
    end else if (i_valid && d_illegal && o_illegal_cnt != '1) begin
      o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
    end
  end

`ifdef DECODER_REG_OUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_opcode    <= '0;
      o_rd        <= '0;
      o_funct3    <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_funct7    <= '0;
      o_immediate <= '0;
      o_imm_ext   <= '0;
      o_format    <= FMT_INVALID;
      o_illegal   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_opcode    <= opcode;
        o_rd        <= i_instruction[11:7];
        o_funct3    <= funct3;
        o_rs1       <= i_instruction[19:15];
        o_rs2       <= i_instruction[24:20];
        o_funct7    <= funct7;
        o_immediate <= i_instruction[31:20];
        o_imm_ext   <= d_imm_ext;
        o_format    <= d_format;
        o_illegal   <= d_illegal;
      end
    end
  end
`else
  assign o_valid     = i_valid;
  assign o_opcode    = opcode;
  assign o_rd        = i_instruction[11:7];
  assign o_funct3    = funct3;
  assign o_rs1       = i_instruction[19:15];
  assign o_rs2       = i_instruction[24:20];
  assign o_funct7    = funct7;
  assign o_immediate = i_instruction[31:20];
  assign o_imm_ext   = d_imm_ext;
  assign o_format    = d_format;
  assign o_illegal   = d_illegal;
`endif

endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// Self-checking bench for rv32i_instr_decoder: vector table through a scoreboard,
// plus hand sequences for the counter, output latency and asynchronous reset.
module tb_rv32i_instr_decoder;
  import rv32i_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int EXP_W    = 68;
  localparam int N_VEC    = 27;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_valid;
  logic [31:0]         i_instruction;
  logic                i_clr_cnt;
  logic                o_valid;
  logic [6:0]          o_opcode;
  logic [4:0]          o_rd;
  logic [2:0]          o_funct3;
  logic [4:0]          o_rs1;
  logic [4:0]          o_rs2;
  logic [6:0]          o_funct7;
  logic [11:0]         o_immediate;
  logic [31:0]         o_imm_ext;
  logic [2:0]          o_format;
  logic                o_illegal;
  logic [TB_CNT_W-1:0] o_illegal_cnt;

  rv32i_instr_decoder #(.CNT_W(TB_CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (i_valid),
    .i_instruction (i_instruction),
    .i_clr_cnt     (i_clr_cnt),
    .o_valid       (o_valid),
    .o_opcode      (o_opcode),
    .o_rd          (o_rd),
    .o_funct3      (o_funct3),
    .o_rs1         (o_rs1),
    .o_rs2         (o_rs2),
    .o_funct7      (o_funct7),
    .o_immediate   (o_immediate),
    .o_imm_ext     (o_imm_ext),
    .o_format      (o_format),
    .o_illegal     (o_illegal),
    .o_illegal_cnt (o_illegal_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    format_e     fmt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t                vecs[N_VEC];
  logic [EXP_W-1:0]    exp_q[$];
  logic [TB_CNT_W-1:0] exp_cnt;
  logic                mon_en = 1'b0;
  int                  n_tests = 0;
  int                  n_fail  = 0;
  int                  n_pop   = 0;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Field outputs are pure slices of the instruction word.
  always @(negedge clk) begin
    if (mon_en && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", n_pop, 64'd1, 64'd0);
      end else begin
        logic [EXP_W-1:0] e;
        logic [31:0]      ins;
        e   = exp_q.pop_front();
        ins = e[67:36];
        check("fields", n_pop,
              {20'd0, o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode, o_immediate},
              {20'd0, ins[31:25], ins[24:20], ins[19:15], ins[14:12], ins[11:7], ins[6:0],
               ins[31:20]});
        check("format", n_pop, {61'd0, o_format}, {61'd0, e[35:33]});
        check("imm_ext", n_pop, {32'd0, o_imm_ext}, {32'd0, e[32:1]});
        check("illegal", n_pop, {63'd0, o_illegal}, {63'd0, e[0]});
        n_pop++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input vec_t v, input logic vld, input logic clr);
    @(posedge clk);
    #1;
    i_valid       = vld;
    i_instruction = v.instr;
    i_clr_cnt     = clr;
    if (vld) exp_q.push_back({v.instr, v.fmt, v.imm, v.ill});
    @(negedge clk);
    check("illegal_cnt", n_tests, {60'd0, o_illegal_cnt}, {60'd0, exp_cnt});
    if (clr) exp_cnt = '0;
    else if (vld && v.ill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic idle();
    vec_t v;
    v = '{$urandom(), FMT_INVALID, 32'h0, 1'b0};
    drive(v, 1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t nop_v, zero_v;
    vecs[0]  = '{32'h00000013, FMT_I,       32'h00000000, 1'b0};
    vecs[1]  = '{32'h00108093, FMT_I,       32'h00000001, 1'b0};
    vecs[2]  = '{32'hFFFF8113, FMT_I,       32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{32'h0020A423, FMT_S,       32'h00000008, 1'b0};
    vecs[4]  = '{32'h123450B7, FMT_U,       32'h12345000, 1'b0};
    vecs[5]  = '{32'h00000000, FMT_INVALID, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h002081B3, FMT_R,       32'h00000000, 1'b0};
    vecs[7]  = '{32'h402081B3, FMT_R,       32'h00000000, 1'b0};
    vecs[8]  = '{32'h402091B3, FMT_R,       32'h00000000, 1'b1};
    vecs[9]  = '{32'h022081B3, FMT_R,       32'h00000000, 1'b1};
    vecs[10] = '{32'h4030D093, FMT_I,       32'h00000403, 1'b0};
    vecs[11] = '{32'h40309093, FMT_I,       32'h00000403, 1'b1};
    vecs[12] = '{32'hFE208EE3, FMT_B,       32'hFFFFFFFC, 1'b0};
    vecs[13] = '{32'hFE20AEE3, FMT_B,       32'hFFFFFFFC, 1'b1};
    vecs[14] = '{32'h008000EF, FMT_J,       32'h00000008, 1'b0};
    vecs[15] = '{32'hFFDFF0EF, FMT_J,       32'hFFFFFFFC, 1'b0};
    vecs[16] = '{32'h00009067, FMT_I,       32'h00000000, 1'b1};
    vecs[17] = '{32'h0000B083, FMT_I,       32'h00000000, 1'b1};
    vecs[18] = '{32'h0040A083, FMT_I,       32'h00000004, 1'b0};
    vecs[19] = '{32'h0020B423, FMT_S,       32'h00000008, 1'b1};
    vecs[20] = '{32'h00000010, FMT_INVALID, 32'h00000000, 1'b1};
    vecs[21] = '{32'hFFFFF097, FMT_U,       32'hFFFFF000, 1'b0};
    vecs[22] = '{32'h00000073, FMT_I,       32'h00000000, 1'b0};
    vecs[23] = '{32'h0FF0000F, FMT_I,       32'h000000FF, 1'b0};
    vecs[24] = '{32'hFE20AE23, FMT_S,       32'hFFFFFFFC, 1'b0};
    vecs[25] = '{32'h0230D093, FMT_I,       32'h00000023, 1'b1};
    vecs[26] = '{32'h00309093, FMT_I,       32'h00000003, 1'b0};
    nop_v  = vecs[0];
    zero_v = vecs[5];

    rst_n         = 1'b0;
    i_valid       = 1'b0;
    i_instruction = 32'h0;
    i_clr_cnt     = 1'b0;
    exp_cnt       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt", 0, {60'd0, o_illegal_cnt}, 64'd0);
`ifdef DECODER_REG_OUT_EN
    check("reset_valid", 0, {63'd0, o_valid}, 64'd0);
    check("reset_format", 0, {61'd0, o_format}, {61'd0, FMT_INVALID});
`endif
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table through the scoreboard with random idle gaps.
    for (int i = 0; i < N_VEC; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      drive(vecs[i], 1'b1, 1'b0);
    end
    idle();
    idle();

    // Counter: count, ignore invalid, clear priority, saturation.
    drive(nop_v, 1'b1, 1'b1);
    drive(zero_v, 1'b1, 1'b0);
    drive(zero_v, 1'b0, 1'b0);
    check("cnt_after_one", 0, {60'd0, o_illegal_cnt}, 64'd1);
    drive(zero_v, 1'b1, 1'b1);
    drive(nop_v, 1'b1, 1'b0);
    check("cnt_clr_priority", 0, {60'd0, o_illegal_cnt}, 64'd0);
    for (int i = 0; i < 20; i++) drive(zero_v, 1'b1, 1'b0);
    idle();
    check("cnt_saturate", 0, {60'd0, o_illegal_cnt}, 64'd15);
    idle();
    idle();
    mon_en = 1'b0;
    check("scoreboard_drained", 0, 64'(exp_q.size()), 64'd0);

    // Output latency and hold behaviour.
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_instruction = 32'h00108093;
    #1;
`ifdef DECODER_REG_OUT_EN
    check("lat_before_edge", 0, {63'd0, o_valid}, 64'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_instruction = 32'h0;
    check("lat_valid", 0, {63'd0, o_valid}, 64'd1);
    check("lat_imm", 0, {32'd0, o_imm_ext}, 64'd1);
    check("lat_rd", 0, {59'd0, o_rd}, 64'd1);
    @(posedge clk);
    #1;
    check("hold_valid_drop", 0, {63'd0, o_valid}, 64'd0);
    check("hold_rd", 0, {59'd0, o_rd}, 64'd1);
    check("hold_imm", 0, {32'd0, o_imm_ext}, 64'd1);
`else
    check("comb_valid", 0, {63'd0, o_valid}, 64'd1);
    check("comb_imm", 0, {32'd0, o_imm_ext}, 64'd1);
    check("comb_rd", 0, {59'd0, o_rd}, 64'd1);
    i_valid = 1'b0;
    i_instruction = 32'h0;
    #1;
    check("comb_valid_drop", 0, {63'd0, o_valid}, 64'd0);
    check("comb_invalid_fmt", 0, {61'd0, o_format}, {61'd0, FMT_INVALID});
`endif

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_instruction = 32'h00000000;
    @(posedge clk);
    #1;
    i_instruction = 32'h00108093;
    check("cnt_pre_reset", 0, {60'd0, o_illegal_cnt}, 64'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 0, {60'd0, o_illegal_cnt}, 64'd0);
`ifdef DECODER_REG_OUT_EN
    check("async_valid", 0, {63'd0, o_valid}, 64'd0);
    check("async_format", 0, {61'd0, o_format}, {61'd0, FMT_INVALID});
    check("async_imm", 0, {32'd0, o_imm_ext}, 64'd0);
    check("async_rd", 0, {59'd0, o_rd}, 64'd0);
`else
    check("async_comb_valid", 0, {63'd0, o_valid}, 64'd1);
    check("async_comb_format", 0, {61'd0, o_format}, {61'd0, FMT_I});
    check("async_comb_imm", 0, {32'd0, o_imm_ext}, 64'd1);
`endif
    @(posedge clk);
    #1;
    check("reset_hold_cnt", 0, {60'd0, o_illegal_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_decoder.md
Name: rv32i_instr_decoder

Overview:
- Decodes one RV32I 32-bit instruction word into raw fields, a format class, a sign-extended immediate and an illegal-instruction flag.
- Sits between instruction fetch and register file / ALU control in the single-issue core.
- The decode path is combinational by default.
- The clocked logic holds the illegal-instruction counter and, optionally, an output register stage.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- i_clk  in  1  core clock; one clock domain; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  i_instruction is valid this cycle.
- i_instruction  in  32  instruction word.
- i_clr_cnt  in  1  synchronous clear of o_illegal_cnt.
- o_valid  out  1  decode outputs are valid.
- o_opcode  out  7  i_instruction[6:0].
- o_rd  out  5  i_instruction[11:7].
- o_funct3  out  3  i_instruction[14:12].
- o_rs1  out  5  i_instruction[19:15].
- o_rs2  out  5  i_instruction[24:20].
- o_funct7  out  7  i_instruction[31:25].
- o_immediate  out  12  raw I-type immediate, i_instruction[31:20], for every opcode.
- o_imm_ext  out  32  format-specific immediate, sign-extended.
- o_format  out  3  format_e code.
- o_illegal  out  1  instruction is not a legal RV32I encoding.
- o_illegal_cnt  out  CNT_W  count of valid illegal instructions.

Behaviour:
- Field outputs are pure bit slices of i_instruction and are independent of opcode.
- Format by opcode:
  - OP 0110011 -> R.
  - OP_IMM 0010011, LOAD 0000011, JALR 1100111, MISC_MEM 0001111, SYSTEM 1110011 -> I.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - LUI 0110111, AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - Any other opcode -> INVALID.
- o_imm_ext per format:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],1'b0}).
  - R and INVALID: 0.
- o_illegal = 1 when any of the following holds:
  - format is INVALID;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 011, 110 or 111;
  - STORE with funct3 above 010;
  - JALR with funct3 not 000;
  - OP with funct7 not 0000000 and not 0100000;
  - OP with funct7 0100000 and funct3 not 000 and not 101;
  - OP_IMM funct3 001 with funct7 not 0000000;
  - OP_IMM funct3 101 with funct7 not 0000000 and not 0100000.
- Encodings whose bits[1:0] are not 11 always map to INVALID.
- Combinational mode: o_valid = i_valid, and all decode outputs have zero latency.
- Counter:
  - Increments on a clock edge when i_valid and o_illegal are both 1.
  - Saturates at all-ones.
  - i_clr_cnt has priority over increment; clear and illegal in the same cycle gives 0.
  - Reset value 0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Combinational outputs are unaffected by reset.

Optional Feature:
- Macro DECODER_REG_OUT_EN.
- When defined:
  - All decode outputs and o_valid are registered; latency is 1 cycle.
  - Registers load only when i_valid = 1; otherwise they hold their value and o_valid drops to 0.
  - Reset values are 0 for every output, with o_format = INVALID.
  - The counter behaves identically and still counts from the combinational o_illegal.
- When undefined: purely combinational decode as described above.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM;
  - typedef enum logic [2:0] format_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_INVALID};
  - the funct7 constants 0000000 and 0100000.
- One sub-module, rv32i_imm_gen (instruction, format -> o_imm_ext), is natural.
- The counter stays inline.

Test Plan:
- 0x00000013 (nop) -> opcode 0010011, rd 0, funct3 000, rs1 0, immediate 0x000, format I, illegal 0.
- 0x00108093 (addi x1,x1,1) -> rd 1, rs1 1, immediate 0x001, imm_ext 0x00000001.
- 0xFFFF8113 -> opcode 0010011, rd 2, funct3 000, rs1 31, immediate 0xFFF, imm_ext 0xFFFFFFFF.
- 0x0020A423 (sw x2,8(x1)) -> format S, rs1 1, rs2 2, funct3 010, imm_ext 0x00000008. Separately, 0x123450B7 (lui x1) -> format U, rd 1, imm_ext 0x12345000.
- Illegal and counter sequence:
  - 0x00000000 with i_valid = 1 -> illegal 1, format INVALID, counter 1 after the edge.
  - Same word with i_valid = 0 -> counter unchanged.
  - Then i_clr_cnt = 1 together with an illegal word -> counter 0.
- With DECODER_REG_OUT_EN defined:
  - Drive 0x00108093 with i_valid = 1 -> outputs appear one edge later with o_valid = 1.
  - Assert i_rst_n = 0 mid-stream -> all outputs 0 immediately, with o_format = INVALID.
